de0_nano_bootrom_arb: RTL and testbench

- Two-master Wishbone arbiter in front of the single-ported boot ROM slave.
- Master 0 is the CPU instruction bus; master 1 is the CPU data bus or debug port.
- Round-robin ownership per bus cycle (held for the whole cyc assertion), so a burst from one master is never split.
- Bus-cycle watchdog returns err to the owner if the slave never acks.

---
 rtl/de0_nano_bootrom_arb_pkg.sv | 22 ++
 rtl/de0_nano_wb_watchdog.sv | 40 ++++
 rtl/de0_nano_bootrom_arb.sv | 108 ++++++++++
 tb/tb_de0_nano_bootrom_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de0_nano_bootrom_arb_pkg.sv
// Shared types and constants for the DE0-Nano boot ROM Wishbone arbiter.
//   arb_state_t     : arbiter ownership state
//   NUM_MASTERS     : number of arbitrated Wishbone masters
//   IDLE_LAST_RESET : value of the round-robin "last owner" after reset
package de0_nano_bootrom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned NUM_MASTERS     = 2;
    // Master 1 counts as the previous owner so master 0 wins the first tie.
    localparam logic        IDLE_LAST_RESET = 1'b1;

    // Ownership state for a given master index.
    function automatic arb_state_t own_state(input logic i_master);
        return i_master ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/de0_nano_wb_watchdog.sv
// Wishbone bus-cycle watchdog.
// Counts consecutive cycles in which a strobe is outstanding without an
// acknowledge and raises a one-cycle timeout pulse on the TIMEOUT-th such cycle.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_active     : a bus owner exists; low clears the counter
//   i_stb        : strobe presented to the slave
//   i_ack        : slave acknowledge (beats a same-cycle timeout)
//   o_timeout    : combinational pulse, high for exactly the expiring cycle
module de0_nano_wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_wait;

    assign w_wait    = i_active & i_stb & ~i_ack;
    assign o_timeout = w_wait & (r_count == LAST);

    // Any cycle that is not a plain wait, including the expiring one, restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!w_wait || o_timeout) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/de0_nano_bootrom_arb.sv
// Two-master round-robin Wishbone arbiter in front of the boot ROM.
// Ownership is held for a whole cyc assertion; an IDLE turnaround cycle
// separates owners. A watchdog returns err to the owner if the ROM never acks.
//   wb_clk_i, wb_rst_i               : clock, asynchronous active-high reset
//   m0_* (instruction), m1_* (data)  : master ports (adr/cyc/stb in, dat/ack/err out)
//   s_*                              : boot ROM slave port
module de0_nano_bootrom_arb
    import de0_nano_bootrom_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i
);

    arb_state_t             r_state;
    logic                   r_last;
    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_own0;
    logic                   w_own1;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_timeout;

    assign w_req  = {m1_cyc_i, m0_cyc_i};
    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

    // stb only counts while the owner also holds cyc.
    assign w_own_cyc = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    assign w_own_stb = (w_own0 & m0_cyc_i & m0_stb_i) | (w_own1 & m1_cyc_i & m1_stb_i);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= IDLE_LAST_RESET;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (&w_req) begin
                        r_state <= own_state(~r_last);
                    end else if (w_req[0]) begin
                        r_state <= OWN0;
                    end else if (w_req[1]) begin
                        r_state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_last  <= w_own1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    de0_nano_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_active  (w_own0 | w_own1),
        .i_stb     (w_own_stb),
        .i_ack     (s_ack_i),
        .o_timeout (w_timeout)
    );

    // Output mux depends only on registered ownership plus the owner's live inputs.
    always_comb begin
        s_adr_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (w_own0) begin
            s_adr_o  = m0_adr_i;
            m0_dat_o = s_dat_i;
        end else if (w_own1) begin
            s_adr_o  = m1_adr_i;
            m1_dat_o = s_dat_i;
        end
        s_cyc_o  = w_own_cyc;
        s_stb_o  = w_own_stb & ~w_timeout;
        m0_ack_o = w_own0 & w_own_stb & s_ack_i;
        m1_ack_o = w_own1 & w_own_stb & s_ack_i;
        m0_err_o = w_own0 & w_timeout;
        m1_err_o = w_own1 & w_timeout;
    end

endmodule

// File: tb/tb_de0_nano_bootrom_arb.sv
module tb_de0_nano_bootrom_arb;

    localparam int unsigned AW = 32;
    localparam int          TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
    logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
    logic [31:0]   m0_dat_o, m1_dat_o, s_dat_i;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic          s_cyc_o, s_stb_o;
    logic          s_ack_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner -1 means nobody owns the bus.
    int mo_owner = -1;
    int mo_last  = 1;
    int mo_wd    = 0;

    logic obs_ack0, obs_ack1, obs_err0, obs_err1, obs_stb;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Boot ROM model: data is a fixed function of the address the arbiter presents.
    assign s_dat_i = rom_word(s_adr_o);

    de0_nano_bootrom_arb #(
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_adr_i (m0_adr_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = 1;
        mo_wd    = 0;
    endtask

    // Called at posedge+1: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic step(input logic c0, input logic s0, input logic [AW-1:0] a0,
                        input logic c1, input logic s1, input logic [AW-1:0] a1,
                        input logic ack);
        logic          ocyc, ostb, tmo;
        logic [AW-1:0] oadr;
        logic          e_ack0, e_ack1, e_err0, e_err1;
        logic [31:0]   e_dat0, e_dat1;
        m0_cyc_i = c0; m0_stb_i = s0; m0_adr_i = a0;
        m1_cyc_i = c1; m1_stb_i = s1; m1_adr_i = a1;
        s_ack_i  = ack;
        ocyc = 1'b0; ostb = 1'b0; tmo = 1'b0; oadr = '0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
        e_dat0 = '0; e_dat1 = '0;
        if (mo_owner >= 0) begin
            ocyc = (mo_owner == 1) ? c1 : c0;
            ostb = ocyc && ((mo_owner == 1) ? s1 : s0);
            oadr = (mo_owner == 1) ? a1 : a0;
            tmo  = ostb && !ack && (mo_wd == TO - 1);
            if (mo_owner == 1) begin
                e_dat1 = rom_word(oadr);
                e_ack1 = ostb && ack;
                e_err1 = tmo;
            end else begin
                e_dat0 = rom_word(oadr);
                e_ack0 = ostb && ack;
                e_err0 = tmo;
            end
        end
        @(negedge clk);
        check_eq("s_cyc", s_cyc_o, ocyc);
        check_eq("s_stb", s_stb_o, ostb && !tmo);
        check_eq("s_adr", s_adr_o, oadr);
        check_eq("m0_dat", m0_dat_o, e_dat0);
        check_eq("m1_dat", m1_dat_o, e_dat1);
        check_eq("m0_ack", m0_ack_o, e_ack0);
        check_eq("m1_ack", m1_ack_o, e_ack1);
        check_eq("m0_err", m0_err_o, e_err0);
        check_eq("m1_err", m1_err_o, e_err1);
        obs_ack0 = m0_ack_o; obs_ack1 = m1_ack_o;
        obs_err0 = m0_err_o; obs_err1 = m1_err_o;
        obs_stb  = s_stb_o;
        @(posedge clk);
        if (mo_owner < 0) begin
            mo_wd = 0;
            if (c0 && c1)  mo_owner = 1 - mo_last;
            else if (c0)   mo_owner = 0;
            else if (c1)   mo_owner = 1;
        end else if (!ocyc) begin
            mo_last  = mo_owner;
            mo_owner = -1;
            mo_wd    = 0;
        end else if (ostb && !ack && !tmo) begin
            mo_wd++;
        end else begin
            mo_wd = 0;
        end
        #1;
    endtask

    // Hold reset with a live request, confirm quiet outputs, release with idle inputs.
    task automatic do_reset();
        rst = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h10;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h20;
        s_ack_i  = 1'b1;
        @(negedge clk);
        check_eq("rst_s_cyc", s_cyc_o, 1'b0);
        check_eq("rst_s_stb", s_stb_o, 1'b0);
        check_eq("rst_s_adr", s_adr_o, '0);
        check_eq("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
        check_eq("rst_dat", {m0_dat_o, m1_dat_o}, 64'd0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i  = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        int acks0, acks1, total, first, errs0, errs1, beats, m0_early;
        logic p0, p1, rc0, rc1, r_ack;
        int ack_pct;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single m0 read at 0x4.
        step(1, 1, 32'h4, 0, 0, 32'h0, 1'b1);
        check_eq("t1_idle_cyc", obs_stb, 1'b0);
        step(1, 1, 32'h4, 0, 0, 32'h0, 1'b1);
        check_eq("t1_ack0", obs_ack0, 1'b1);
        check_eq("t1_ack1", obs_ack1, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // Simultaneous request: m0 first, one IDLE turnaround, then m1.
        do_reset();
        first = 0; acks0 = 0;
        for (int i = 1; i <= 8; i++) begin
            step((i <= 2), (i <= 2), 32'h8, 1, 1, 32'hC, 1'b1);
            if (obs_ack0 && acks0 == 0) acks0 = i;
            if (obs_ack1 && first == 0) first = i;
        end
        check_eq("t2_m0_first", acks0, 2);
        check_eq("t2_m1_after_turn", first, 5);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // Continuous single-beat requests from both: strict alternation.
        do_reset();
        p0 = 1'b1; p1 = 1'b1; acks0 = 0; acks1 = 0; total = 0;
        for (int i = 0; i < 200 && total < 20; i++) begin
            step(p0, p0, 32'(total * 4), p1, p1, 32'(total * 4 + 32'h100), 1'b1);
            p0 = 1'b1; p1 = 1'b1;
            if (obs_ack0) begin
                check_eq("t3_order", 0, total % 2);
                acks0++; total++; p0 = 1'b0;
            end
            if (obs_ack1) begin
                check_eq("t3_order", 1, total % 2);
                acks1++; total++; p1 = 1'b0;
            end
        end
        check_eq("t3_acks0", acks0, 10);
        check_eq("t3_acks1", acks1, 10);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // m1 4-beat burst is not split by a competing m0 request.
        do_reset();
        beats = 0; m0_early = 0; first = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            step((i >= 2), (i >= 2), 32'h40, (beats < 4), (beats < 4), 32'(beats * 4), 1'b1);
            if (obs_ack1) beats++;
            if (obs_ack0) begin
                if (beats < 4) m0_early++;
                first = i;
            end
        end
        check_eq("t4_beats", beats, 4);
        check_eq("t4_m0_early", m0_early, 0);
        check_eq("t4_m0_served", (first != 0), 1'b1);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // Slave never acks: exactly one err on the 8th stb cycle.
        do_reset();
        errs0 = 0; errs1 = 0; first = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1, 1, 32'h80, 0, 0, 32'h0, 1'b0);
            if (obs_err0) begin
                errs0++;
                if (first == 0) first = i;
                check_eq("t5_stb_forced", obs_stb, 1'b0);
            end
            if (obs_err1) errs1++;
        end
        check_eq("t5_err_count", errs0, 1);
        check_eq("t5_err_cycle", first, 9);
        check_eq("t5_err1", errs1, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // Asynchronous reset mid m1 burst, then m0 wins the next tie.
        do_reset();
        step(0, 0, 32'h0, 1, 1, 32'h0, 1'b1);
        step(0, 0, 32'h0, 1, 1, 32'h4, 1'b1);
        check_eq("t6_pre_ack1", obs_ack1, 1'b1);
        m1_adr_i = 32'h8;
        #1;
        check_eq("t6_live_cyc", s_cyc_o, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_async_cyc", s_cyc_o, 1'b0);
        check_eq("t6_async_stb", s_stb_o, 1'b0);
        check_eq("t6_async_ack1", m1_ack_o, 1'b0);
        do_reset();
        step(1, 1, 32'h0, 1, 1, 32'h4, 1'b1);
        step(1, 1, 32'h0, 1, 1, 32'h4, 1'b1);
        check_eq("t6_m0_wins", obs_ack0, 1'b1);
        check_eq("t6_m1_waits", obs_ack1, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1'b0);

        // Randomised traffic against the model, with varying slave responsiveness.
        do_reset();
        rc0 = 1'b0; rc1 = 1'b0; ack_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) ack_pct = (i % 1500 == 0) ? 70 : ((i % 1500 == 500) ? 10 : 0);
            if ($urandom_range(0, 7) == 0) rc0 = ~rc0;
            if ($urandom_range(0, 7) == 0) rc1 = ~rc1;
            r_ack = ($urandom_range(0, 99) < ack_pct);
            step(rc0, rc0 & ($urandom_range(0, 3) != 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 rc1, rc1 & ($urandom_range(0, 3) != 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 r_ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
